// File: rtl/clock_time_counter_if.sv
// clock_time_counter_if
//   Control and status bundle for the time-of-day core.
//   master: drives the user controls (run, set_mode, inc_min, inc_hr,
//           clr_sec) and observes the time fields and pulses.
//   slave : the counter core; consumes the controls and drives
//           sec/min/hr (8-bit binary) plus the sec_tick and day_roll
//           one-cycle pulses.
interface clock_time_counter_if;
  logic       run;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hr;
  logic       clr_sec;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hr;
  logic       sec_tick;
  logic       day_roll;

  modport master (
    output run, set_mode, inc_min, inc_hr, clr_sec,
    input  sec, min, hr, sec_tick, day_roll
  );

  modport slave (
    input  run, set_mode, inc_min, inc_hr, clr_sec,
    output sec, min, hr, sec_tick, day_roll
  );
endinterface

// File: rtl/clock_time_counter.sv
// clock_time_counter
//   Divides clk down to a one-second tick and keeps seconds, minutes and
//   hours as binary counts for the downstream BCD converters.
//   Ports:
//     clk   - system clock, all state updates on the rising edge
//     reset - synchronous, active-high; clears counts, prescaler, pulses
//     bus   - clock_time_counter_if.slave
//             run      : 1 = timekeeping enabled, 0 = everything holds
//             set_mode : 1 = adjust mode (prescaler parked at 0, no ticks)
//             inc_min / inc_hr / clr_sec : single-cycle adjust pulses,
//                        honoured only in adjust mode
//             sec/min/hr : binary counts, unused upper bits are 0
//             sec_tick : high in the cycle a new seconds value appears
//             day_roll : high in the cycle hr wraps to 0 through carry
//   Parameters:
//     TICK_DIV - clk cycles per second tick (>= 2)
//     HOUR_MAX - last hour before wrap to 0 (fits in 5 bits)
module clock_time_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MAX = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  clock_time_counter_if.slave  bus
);

  localparam int                PSC_W    = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_DIV - 1);
  localparam logic [5:0]        SEC_LAST = 6'd59;
  localparam logic [5:0]        MIN_LAST = 6'd59;
  localparam logic [4:0]        HR_LAST  = 5'(HOUR_MAX);

  // The operating mode is decoded straight from set_mode; there is no
  // separate mode register, so a mode change takes effect on the very
  // edge that samples it.
  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  mode_e mode;
  assign mode = bus.set_mode ? MODE_SET : MODE_RUN;

  logic [PSC_W-1:0] psc_q, psc_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q,  hr_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_roll_q, day_roll_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    psc_d      = psc_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_tick_d = 1'b0;
    day_roll_d = 1'b0;

    unique case (mode)
      MODE_SET: begin
        // Parked prescaler means the first tick after leaving adjust mode
        // comes a full TICK_DIV cycles later. A terminal count coinciding
        // with entry into adjust mode is dropped here as well.
        psc_d = '0;
        if (bus.inc_min) min_d = (min_q == MIN_LAST) ? 6'd0 : min_q + 6'd1;
        if (bus.inc_hr)  hr_d  = (hr_q  == HR_LAST)  ? 5'd0 : hr_q  + 5'd1;
        if (bus.clr_sec) sec_d = 6'd0;
      end

      MODE_RUN: begin
        if (bus.run) begin
          if (psc_q == PSC_LAST) begin
            psc_d      = '0;
            sec_tick_d = 1'b1;
            // Whole carry chain resolves in one edge so the display never
            // sees a half-updated time such as min=60.
            if (sec_q == SEC_LAST) begin
              sec_d = 6'd0;
              if (min_q == MIN_LAST) begin
                min_d = 6'd0;
                if (hr_q == HR_LAST) begin
                  hr_d       = 5'd0;
                  day_roll_d = 1'b1;
                end else begin
                  hr_d = hr_q + 5'd1;
                end
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            psc_d = psc_q + PSC_W'(1);
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      psc_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      sec_tick_q <= 1'b0;
      day_roll_q <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= sec_tick_d;
      day_roll_q <= day_roll_d;
    end
  end

  // Upper bits tied low keep each BCD converter input within 0..99.
  assign bus.sec      = {2'b00, sec_q};
  assign bus.min      = {2'b00, min_q};
  assign bus.hr       = {3'b000, hr_q};
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_roll = day_roll_q;

endmodule

// File: doc/clock_time_counter.md
Name: clock_time_counter

Overview:
Time-of-day core for the clock. It divides the system clock down to a 1 Hz tick and keeps seconds, minutes and hours as binary counts. The three 8-bit counts feed the BCD converter stage directly, one BCD instance per field, which drives the display. A set mode lets the user adjust minutes and hours.

Parameters:
TICK_DIV, 50_000_000, system clock cycles per one-second tick; legal range is 2 or more. Benches use 4.
HOUR_MAX, 23, last hour value before wrap to 0.

Ports:
clk  in  1  system clock; every register updates on the rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  1 = timekeeping enabled; 0 = counts and prescaler frozen.
set_mode  in  1  1 = adjust mode.
inc_min  in  1  single-cycle pulse; in set mode, minutes +1.
inc_hr  in  1  single-cycle pulse; in set mode, hours +1.
clr_sec  in  1  single-cycle pulse; in set mode, seconds and prescaler cleared.
sec  out  8  seconds, 0..59, binary, upper bits 0.
min  out  8  minutes, 0..59.
hr  out  8  hours, 0..HOUR_MAX.
sec_tick  out  1  one-cycle pulse, high in the cycle the new seconds value first appears.
day_roll  out  1  one-cycle pulse, high in the cycle hr wraps HOUR_MAX->0 through carry.

Behaviour:
- Reset (sampled at a clk edge while reset=1):
  - sec, min, hr, prescaler cleared to 0; sec_tick and day_roll = 0.
  - Reset has priority over every other input.
  - Reset mid-count discards the partial prescaler count; the next tick arrives a full TICK_DIV cycles after reset deasserts.
- State is set by set_mode, not a separate register: RUN when set_mode=0, SET when set_mode=1.
- RUN, run=1:
  - Prescaler counts 0..TICK_DIV-1.
  - At TICK_DIV-1 the prescaler returns to 0 and a tick occurs at that edge.
  - On a tick, sec increments; the updated value and sec_tick=1 are visible after that edge, so the tick period is exactly TICK_DIV cycles.
  - Carry chain within the same edge:
    - sec 59->0 increments min.
    - min 59->0 increments hr.
    - hr HOUR_MAX->0 also sets day_roll=1 in the same cycle as sec_tick.
  - All fields settle together; no intermediate values are visible.
- RUN, run=0: prescaler and counts hold; no pulses.
- inc_min, inc_hr and clr_sec are ignored in RUN.
- SET:
  - Prescaler is held at 0 and no ticks occur, regardless of run.
  - inc_min: min+1 with wrap 59->0. No carry into hr.
  - inc_hr: hr+1 with wrap HOUR_MAX->0. day_roll stays 0.
  - clr_sec: sec=0.
  - Simultaneous pulses in SET are each applied to their own field in the same edge.
  - sec_tick and day_roll = 0 throughout SET.
- SET->RUN transition: the prescaler starts from 0, so the first tick arrives TICK_DIV cycles after set_mode falls (run=1).
- RUN->SET in the same cycle the prescaler reaches terminal count: SET wins and the tick is dropped.
- Width rules:
  - Internal prescaler width is $clog2(TICK_DIV).
  - Output bits [7:6] of sec/min and [7:5] of hr are always 0, which keeps the downstream BCD input within 0..99.
- sec_tick and day_roll are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset, then run=1, TICK_DIV=4, 12 cycles -> sec_tick high on cycles 4, 8, 12; sec reads 1, 2, 3; min=hr=0.
2. set_mode=1, 59 inc_min pulses, set_mode=0, run for 60 ticks -> at the 60th tick sec=0, min=0, hr=1 all in the same cycle; no intermediate min=60 seen.
3. Set hr=23, min=59 via inc pulses (set_mode=1), set_mode=0, run 60 ticks -> hr=0, min=0, sec=0; day_roll and sec_tick both high for exactly 1 cycle.
4. set_mode=1 with hr=23 and one inc_hr pulse -> hr=0, day_roll=0; inc_min in RUN leaves min unchanged.
5. run=1, assert reset at prescaler=2 with sec=5 -> next cycle all outputs are 0; first sec_tick arrives 4 cycles after reset deasserts.
6. run=0 for 10 cycles mid-count, then run=1 -> counts frozen while run=0; the tick resumes from the held prescaler value with no extra or lost tick.
